// File: rtl/up_dn_cnt_pkg.sv
// Shared constants for the parametrised up/down counter: mode and direction encodings.
package up_dn_cnt_pkg;

  localparam logic [1:0] MODE_SAT    = 2'd0;
  localparam logic [1:0] MODE_WRAP   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/up_dn_cnt_next.sv
// Combinational next-state for the up/down counter: computes the next count, bounce direction
// and terminal flag from the current count, step, request, mode and direction.
module up_dn_cnt_next
  import up_dn_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic             up_i,
  input  logic             dn_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             dir_o,
  output logic             tc_o
);

  localparam logic [WIDTH:0] MinX = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] MaxX = (WIDTH+1)'(MAX_VAL);

  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] dn_diff;
  logic           up_cross;
  logic           dn_cross;

  assign up_sum   = {1'b0, cnt_i} + {1'b0, step_i};
  assign dn_diff  = {1'b0, cnt_i} - {1'b0, step_i};
  assign up_cross = up_sum > MaxX;
  // Top bit of the difference is the borrow out of the WIDTH-bit subtract.
  assign dn_cross = dn_diff[WIDTH] | (dn_diff < MinX);

  always_comb begin
    cnt_o = cnt_i;
    dir_o = dir_i;
    tc_o  = 1'b0;
    if (step_i != '0) begin
      unique case (mode_i)
        MODE_SAT: begin
          if (dn_i) begin
            cnt_o = dn_cross ? MinX[WIDTH-1:0] : dn_diff[WIDTH-1:0];
            tc_o  = dn_cross;
          end else if (up_i) begin
            cnt_o = up_cross ? MaxX[WIDTH-1:0] : up_sum[WIDTH-1:0];
            tc_o  = up_cross;
          end
        end
        MODE_WRAP: begin
          if (dn_i) begin
            cnt_o = dn_cross ? MaxX[WIDTH-1:0] : dn_diff[WIDTH-1:0];
            tc_o  = dn_cross;
          end else if (up_i) begin
            cnt_o = up_cross ? MinX[WIDTH-1:0] : up_sum[WIDTH-1:0];
            tc_o  = up_cross;
          end
        end
        MODE_BOUNCE: begin
          if (up_i || dn_i) begin
            if (dir_i == DIR_UP) begin
              if (up_cross || (up_sum == MaxX)) begin
                cnt_o = MaxX[WIDTH-1:0];
                dir_o = DIR_DN;
                tc_o  = 1'b1;
              end else begin
                cnt_o = up_sum[WIDTH-1:0];
              end
            end else begin
              if (dn_cross || (dn_diff == MinX)) begin
                cnt_o = MinX[WIDTH-1:0];
                dir_o = DIR_UP;
                tc_o  = 1'b1;
              end else begin
                cnt_o = dn_diff[WIDTH-1:0];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/up_dn_counter_param.sv
// Parametrised up/down counter with saturate/wrap/bounce/hold modes and a registered TC pulse.
// Optional sticky terminal flag built when UP_DN_CNT_STICKY_EN is defined.
module up_dn_counter_param
  import up_dn_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  input  logic [WIDTH-1:0] STEP,
  input  logic             Load,
  input  logic             Up,
  input  logic             Down,
  input  logic [1:0]       Mode,
`ifdef UP_DN_CNT_STICKY_EN
  input  logic             Clr_Sticky,
  output logic             Sticky,
`endif
  output logic [WIDTH-1:0] Counter,
  output logic             High,
  output logic             Low,
  output logic             TC,
  output logic             Dir
);

  localparam logic [WIDTH-1:0] MinV = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
  logic             dir_q, dir_d, dir_nxt;
  logic             tc_q, tc_d, tc_nxt;

  up_dn_cnt_next #(
    .WIDTH  (WIDTH),
    .MIN_VAL(MIN_VAL),
    .MAX_VAL(MAX_VAL)
  ) u_next (
    .cnt_i (cnt_q),
    .step_i(STEP),
    .up_i  (Up),
    .dn_i  (Down),
    .mode_i(Mode),
    .dir_i (dir_q),
    .cnt_o (cnt_nxt),
    .dir_o (dir_nxt),
    .tc_o  (tc_nxt)
  );

  always_comb begin
    cnt_d = cnt_nxt;
    dir_d = dir_nxt;
    tc_d  = tc_nxt;
    if (Load) begin
      if (IN > MaxV)      cnt_d = MaxV;
      else if (IN < MinV) cnt_d = MinV;
      else                cnt_d = IN;
      dir_d = dir_q;
      tc_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= MinV;
      dir_q <= DIR_UP;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      tc_q  <= tc_d;
    end
  end

`ifdef UP_DN_CNT_STICKY_EN
  logic sticky_q, sticky_d;

  // A terminal event in the same cycle as a clear keeps the flag set.
  assign sticky_d = tc_d | (sticky_q & ~Clr_Sticky);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sticky_q <= 1'b0;
    else      sticky_q <= sticky_d;
  end

  assign Sticky = sticky_q;
`endif

  assign Counter = cnt_q;
  assign Dir     = dir_q;
  assign TC      = tc_q;
  assign High    = (cnt_q == MaxV);
  assign Low     = (cnt_q == MinV);

endmodule

// File: tb/tb_up_dn_counter_param.sv
// Directed self-checking bench: default, offset-range (2..20) and 6-bit (max 35) instances.
module tb_up_dn_counter_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0, up = 1'b0, down = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [5:0] st = '0;
  logic [4:0] in_a = '0, in_b = '0;
  logic [5:0] in_c = '0;

  logic [4:0] cnt_a, cnt_b;
  logic [5:0] cnt_c;
  logic       hi_a, lo_a, tc_a, dir_a;
  logic       hi_b, lo_b, tc_b, dir_b;
  logic       hi_c, lo_c, tc_c, dir_c;
`ifdef UP_DN_CNT_STICKY_EN
  logic clr = 1'b0;
  logic sticky_a, sticky_b, sticky_c;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  up_dn_counter_param u_dut_a (
    .CLK(clk), .RST(rst_n), .IN(in_a), .STEP(st[4:0]), .Load(load), .Up(up), .Down(down),
    .Mode(mode),
`ifdef UP_DN_CNT_STICKY_EN
    .Clr_Sticky(clr), .Sticky(sticky_a),
`endif
    .Counter(cnt_a), .High(hi_a), .Low(lo_a), .TC(tc_a), .Dir(dir_a)
  );

  up_dn_counter_param #(.WIDTH(5), .MIN_VAL(2), .MAX_VAL(20)) u_dut_b (
    .CLK(clk), .RST(rst_n), .IN(in_b), .STEP(st[4:0]), .Load(load), .Up(up), .Down(down),
    .Mode(mode),
`ifdef UP_DN_CNT_STICKY_EN
    .Clr_Sticky(clr), .Sticky(sticky_b),
`endif
    .Counter(cnt_b), .High(hi_b), .Low(lo_b), .TC(tc_b), .Dir(dir_b)
  );

  up_dn_counter_param #(.WIDTH(6), .MIN_VAL(0), .MAX_VAL(35)) u_dut_c (
    .CLK(clk), .RST(rst_n), .IN(in_c), .STEP(st), .Load(load), .Up(up), .Down(down),
    .Mode(mode),
`ifdef UP_DN_CNT_STICKY_EN
    .Clr_Sticky(clr), .Sticky(sticky_c),
`endif
    .Counter(cnt_c), .High(hi_c), .Low(lo_c), .TC(tc_c), .Dir(dir_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_seq [14] = '{29, 31, 28, 25, 22, 19, 16, 13, 10, 7, 4, 1, 0, 3};

  initial begin
    logic exp_dir;
    #12 rst_n = 1'b1;
    tick();

    // Load 17 then assert reset between edges.
    in_a = 5'd17; load = 1'b1; tick(); load = 1'b0;
    check("load17", cnt_a, 17);
    #2 rst_n = 1'b0;
    #1;
    check("rst_cnt", cnt_a, 0);
    check("rst_dir", dir_a, 1);
    check("rst_tc", tc_a, 0);
    check("rst_low", lo_a, 1);
    #1 rst_n = 1'b1;
    tick();

    // SAT.
    mode = 2'd0; in_a = 5'd29; in_b = 5'd18; in_c = 6'd40; load = 1'b1; tick(); load = 1'b0;
    check("b_load18", cnt_b, 18);
    check("c_load_clamp", cnt_c, 35);
    up = 1'b1; st = 6'd4; tick();
    check("sat_clip", cnt_a, 31);
    check("sat_clip_tc", tc_a, 1);
    check("sat_high", hi_a, 1);
    tick();
    check("sat_hold", cnt_a, 31);
    check("sat_hold_tc", tc_a, 1);
    down = 1'b1; st = 6'd1; tick();
    check("sat_dn_wins", cnt_a, 30);
    check("sat_dn_tc", tc_a, 0);
    down = 1'b0; st = 6'd0; tick();
    check("step0_cnt", cnt_a, 30);
    check("step0_tc", tc_a, 0);

    // WRAP on the 2..20 instance.
    up = 1'b0; load = 1'b1; in_b = 5'd18; tick(); load = 1'b0;
    mode = 2'd1; up = 1'b1; st = 6'd5; tick();
    check("wrap_up", cnt_b, 2);
    check("wrap_up_tc", tc_b, 1);
    check("wrap_low", lo_b, 1);
    up = 1'b0; down = 1'b1; st = 6'd1; tick();
    check("wrap_dn", cnt_b, 20);
    check("wrap_dn_tc", tc_b, 1);
    check("wrap_dir_kept", dir_b, 1);
    down = 1'b0; tick();
    check("tc_clears", tc_b, 0);

    // BOUNCE.
    mode = 2'd0; in_a = 5'd26; load = 1'b1; tick(); load = 1'b0;
    mode = 2'd2; up = 1'b1; st = 6'd3;
    exp_dir = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (exp_seq[i] == 31) exp_dir = 1'b0;
      if (exp_seq[i] == 0)  exp_dir = 1'b1;
      check($sformatf("bnc_cnt[%0d]", i), cnt_a, exp_seq[i]);
      check($sformatf("bnc_tc[%0d]", i), tc_a, (exp_seq[i] == 31 || exp_seq[i] == 0) ? 1 : 0);
      check($sformatf("bnc_dir[%0d]", i), dir_a, exp_dir);
    end

    // Load clamps and beats Up; HOLD ignores Up.
    mode = 2'd0; in_c = 6'd40; load = 1'b1; up = 1'b1; st = 6'd1; tick(); load = 1'b0;
    check("ld_clamp", cnt_c, 35);
    check("ld_high", hi_c, 1);
    check("ld_tc", tc_c, 0);
    in_c = 6'd10; load = 1'b1; tick(); load = 1'b0;
    mode = 2'd3; tick();
    check("hold_cnt", cnt_c, 10);
    check("hold_tc", tc_c, 0);
    in_c = 6'd20; load = 1'b1; tick(); load = 1'b0;
    check("hold_load", cnt_c, 20);
    up = 1'b0;

`ifdef UP_DN_CNT_STICKY_EN
    mode = 2'd3; clr = 1'b1; tick(); clr = 1'b0;
    check("stk_clr0", sticky_a, 0);
    mode = 2'd0; in_a = 5'd30; load = 1'b1; tick(); load = 1'b0;
    up = 1'b1; st = 6'd4; tick(); up = 1'b0;
    check("stk_set", sticky_a, 1);
    tick();
    check("stk_holds", sticky_a, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("stk_clr", sticky_a, 0);
    clr = 1'b1; up = 1'b1; tick(); clr = 1'b0; up = 1'b0;
    check("stk_set_wins", sticky_a, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/up_dn_counter_param.md
Name: up_dn_counter_param

Overview:
Parametrised successor to the 5-bit up/down counter.
- Configurable width and count limits.
- Programmable step size per cycle.
- Runtime-selectable end-of-range mode: saturate, wrap or bounce (ping-pong).
- Registered terminal-count pulse.
- Used as a generic event/position counter in control datapaths.

Parameters:
WIDTH, 5, counter/data width in bits (>=2)
MIN_VAL, 0, lower count limit (unsigned, < MAX_VAL)
MAX_VAL, 2**WIDTH-1, upper count limit (unsigned, <= 2**WIDTH-1)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
IN  input  WIDTH  load value
STEP  input  WIDTH  increment/decrement amount
Load  input  1  load IN (highest priority)
Up  input  1  count-up request
Down  input  1  count-down request (wins over Up)
Mode  input  2  0=SAT, 1=WRAP, 2=BOUNCE, 3=HOLD
Counter  output  WIDTH  registered count
High  output  1  Counter == MAX_VAL (combinational from Counter)
Low  output  1  Counter == MIN_VAL (combinational from Counter)
TC  output  1  registered 1-cycle terminal-count pulse
Dir  output  1  bounce direction state, 1=up

Behaviour:
- Reset (RST=0, async): Counter=MIN_VAL, Dir=1, TC=0. Release is synchronous to the next CLK edge.
- Priority per cycle: Load > Down > Up > hold. All outputs update one cycle after inputs are sampled.
- Load: Counter <= IN clamped to [MIN_VAL, MAX_VAL]; TC=0; Dir unchanged. Load is honoured in every Mode, including HOLD.
- Arithmetic is done in WIDTH+1 bits:
  - up candidate = Counter + STEP
  - down candidate = Counter - STEP, with a borrow flag
  - crossing = up candidate > MAX_VAL, or down candidate < MIN_VAL (or borrow)
- STEP=0: Counter unchanged, TC=0.
- SAT: on crossing, clip to MAX_VAL (up) or MIN_VAL (down) and TC=1. Already at the limit with a request in the same direction: hold, TC=1.
- WRAP: on up crossing, Counter <= MIN_VAL. On down crossing, Counter <= MAX_VAL. TC=1. The partial step residue is discarded.
- BOUNCE: Up|Down acts only as an enable; direction comes from the Dir FSM.
  - State UP (Dir=1): advance +STEP. On crossing or landing exactly on MAX_VAL: Counter <= MAX_VAL, go to DN, TC=1.
  - State DN (Dir=0): advance -STEP. On crossing or landing on MIN_VAL: Counter <= MIN_VAL, go to UP, TC=1.
- HOLD: Up/Down ignored, Counter held, TC=0.
- Dir changes only in BOUNCE. A Mode change mid-count takes effect next cycle and keeps Dir.
- Up and Down together: Down wins, except in BOUNCE where both simply enable.
- TC clears the cycle after any cycle with no terminal event.

Optional Feature:
Macro UP_DN_CNT_STICKY_EN.
- Defined: adds ports Clr_Sticky (input, 1) and Sticky (output, 1).
  - Sticky sets on any TC event and holds until Clr_Sticky=1.
  - Set wins over a simultaneous clear.
  - Reset value is 0.
- Undefined: neither port exists and no extra flop is built. All other behaviour is identical.

Decomposition:
- Package up_dn_cnt_pkg holds:
  - Mode constants MODE_SAT=2'd0, MODE_WRAP=2'd1, MODE_BOUNCE=2'd2, MODE_HOLD=2'd3.
  - Dir encodings DIR_UP=1'b1, DIR_DN=1'b0.
- Sub-module up_dn_cnt_next is a natural split: purely combinational. It takes Counter, STEP, direction and Mode and produces next count, next Dir and the terminal flag.
- The top level holds the registers, load and priority logic, and the optional sticky flop.

Test Plan:
- Defaults. Reset low mid-count at Counter=17 -> Counter=0, Dir=1, TC=0 immediately, without waiting for a clock edge.
- SAT, STEP=4, Counter=29, Up -> Counter=31 and TC=1. Next Up -> Counter stays 31, TC=1. Then Up=Down=1, STEP=1 -> Counter=30, TC=0.
- WRAP, MIN_VAL=2, MAX_VAL=20, Counter=18, STEP=5, Up -> Counter=2, TC=1. Down with STEP=1 -> Counter=20, TC=1.
- BOUNCE, STEP=3, Counter=26, Up held -> 29, 31 (Dir->0, TC=1), 28, 25, ... 1, 0 (Dir->1, TC=1), 3.
- Load IN=40 with WIDTH=6, MAX_VAL=35, Up=1 in the same cycle -> Counter=35, High=1, TC=0. HOLD with Up -> unchanged.
- UP_DN_CNT_STICKY_EN build: TC event -> Sticky=1. Clr_Sticky with no event -> 0. Clr_Sticky coincident with a TC event -> stays 1.
